// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter and select sequencer for the 16:1 mux datapath.
// Grants one requester at a time for up to BURST accepted beats. Drives the
// mux select and a one-hot grant. Reloads the next winner on the release edge,
// so no bubble cycle appears between grants.
module mux16_rr_arbiter #(
    parameter int unsigned BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:15] req,
    output logic [0:3]  sel,
    output logic [0:15] gnt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        last,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

    state_t      state, state_n;
    logic [3:0]  ptr, ptr_n;
    logic [3:0]  cnt, cnt_n;
    logic [0:3]  sel_n;
    logic [0:15] gnt_n;

    logic [3:0]  base;
    logic [3:0]  idx;
    logic [3:0]  win;
    logic        found;

    logic        cur_req;
    logic        beat;
    logic        final_beat;
    logic        rel_g;

    assign cur_req    = req[sel];
    assign busy       = (state == GRANT);
    assign out_valid  = busy & cur_req;
    assign beat       = out_valid & out_ready;
    assign last       = out_valid & (cnt == LAST_CNT);
    assign final_beat = beat & (cnt == LAST_CNT);
    assign rel_g      = busy & (final_beat | ~cur_req);

    // Round-robin search: starts after the last granted index and visits that
    // index last. While a grant is held, ptr is about to become sel on
    // release, so sel is used as the base directly.
    always_comb begin
        base  = busy ? sel : ptr;
        found = 1'b0;
        win   = base;
        idx   = base;
        for (int unsigned i = 1; i <= 16; i++) begin
            idx = base + 4'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state and register-update logic for the grant sequencer.
    always_comb begin
        state_n = state;
        sel_n   = sel;
        gnt_n   = gnt;
        cnt_n   = cnt;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n     = GRANT;
                    sel_n       = win;
                    gnt_n       = '0;
                    gnt_n[win]  = 1'b1;
                    cnt_n       = '0;
                end
            end
            GRANT: begin
                if (rel_g) begin
                    ptr_n = sel;
                    cnt_n = '0;
                    if (found) begin
                        sel_n      = win;
                        gnt_n      = '0;
                        gnt_n[win] = 1'b1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end else if (beat) begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // State and grant registers; asynchronous reset discards any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            gnt   <= '0;
            cnt   <= '0;
            ptr   <= '1;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            gnt   <= gnt_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
        end
    end

endmodule
